bcd_encode_seq: RTL and testbench

//  Sequential BCD-to-binary encoder: the inverse of the binary-to-BCD digit decoder used for display.

---
 rtl/bcd_encode_seq.sv | 144 ++++++++++++++
 tb/tb_bcd_encode_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_encode_seq.sv
// -----------------------------------------------------------------------------
// bcd_encode_seq
// Sequential BCD-to-binary encoder. A packed word of NDIG BCD digits (most
// significant digit in the top nibble) is accepted in IDLE. It is converted by
// multiply-by-10-and-add, one digit per clock, and returned as a binary value
// with an error flag.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active high
//   in_valid   in_bcd carries a word
//   in_ready   block can accept a word (IDLE only, low while rst=1)
//   in_bcd     packed BCD, [4*NDIG-1 -: 4] is the most significant digit
//   out_valid  out_bin / out_err hold a result
//   out_ready  consumer takes the result
//   out_bin    binary result, 0 when out_err=1
//   out_err    some digit > 9, or value > MAX
// -----------------------------------------------------------------------------
module bcd_encode_seq #(
    parameter int NDIG = 2,
    parameter int MAX  = 99,
    parameter int W    = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG-1:0] in_bcd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_bin,
    output logic              out_err
);

    // Accumulator wide enough for the largest all-valid word (10**NDIG - 1).
    localparam int AW = $clog2(10**NDIG);
    localparam int CW = $clog2(NDIG + 1);
    localparam logic [31:0] MAX_U = MAX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [4*NDIG-1:0]   sr_q, sr_d;
    logic [AW-1:0]       acc_q, acc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                out_valid_q, out_valid_d;
    logic [W-1:0]        out_bin_q, out_bin_d;
    logic                out_err_q, out_err_d;

    logic [3:0]          digit;
    logic                bad_word;

    assign digit    = sr_q[4*NDIG-1 -: 4];
    assign bad_word = err_q | (32'(acc_q) > MAX_U);

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_bin_d   = out_bin_q;
        out_err_d   = out_err_q;

        case (state_q)
            IDLE: begin
                // in_ready is exactly "IDLE and not in reset", so in_valid
                // alone qualifies the accept here.
                if (in_valid) begin
                    sr_d    = in_bcd;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = CONV;
                end
            end

            CONV: begin
                sr_d  = sr_q << 4;
                cnt_d = cnt_q + CW'(1);
                // A bad digit freezes acc, so acc never exceeds 10**NDIG-1
                // and the AW-wide multiply-add cannot overflow.
                if (digit > 4'd9) begin
                    err_d = 1'b1;
                end else if (!err_q) begin
                    acc_d = acc_q * AW'(10) + AW'(digit);
                end
                if (cnt_q == CW'(NDIG - 1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                // First DONE cycle loads the result registers; afterwards
                // they hold until the consumer handshakes.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_err_d   = bad_word;
                    out_bin_d   = bad_word ? '0 : W'(acc_q);
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_bin_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_bin_q   <= out_bin_d;
            out_err_q   <= out_err_d;
        end
    end

    // Gated by rst so the handshake is refused while reset is held.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out_bin   = out_bin_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_bcd_encode_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd_encode_seq
// Two encoders share one input stream: MAX=99 and MAX=59. A behavioural model
// tracks each word from accept to handshake and predicts in_ready, out_valid
// and the result. Directed words pin the model with hand-computed values, then
// random traffic runs against the model.
// -----------------------------------------------------------------------------
module tb_bcd_encode_seq;

    localparam int NDIG = 2;
    localparam int W    = 7;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic [4*NDIG-1:0]     in_bcd = '0;
    logic                  out_ready = 1'b0;
    logic [1:0]            in_ready_w, out_valid_w, out_err_w;
    logic [1:0][W-1:0]     out_bin_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_encode_seq #(.NDIG(NDIG), .MAX(99), .W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .in_bcd(in_bcd), .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_bin(out_bin_w[0]), .out_err(out_err_w[0])
    );

    bcd_encode_seq #(.NDIG(NDIG), .MAX(59), .W(W)) dut59 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .in_bcd(in_bcd), .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_bin(out_bin_w[1]), .out_err(out_err_w[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int max_of(input int i);
        return (i == 0) ? 99 : 59;
    endfunction

    // Reference: decimal value of the digits, error on any digit > 9 or value > max.
    task automatic ref_conv(input logic [4*NDIG-1:0] bcd, input int maxv,
                            output int bin, output int err);
        int v;
        int dg;
        v   = 0;
        err = 0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            dg = int'((bcd >> (4 * k)) & 'hF);
            if (dg > 9) err = 1;
            v = v * 10 + dg;
        end
        if (v > maxv) err = 1;
        bin = err ? 0 : v;
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    bit mdl_busy = 0;
    int mdl_age  = 0;      // edges since the accept edge
    int mdl_bin [2];
    int mdl_err [2];

    always @(negedge clk) begin
        bit exp_vld;
        int b;
        int e;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rst_in_ready[%0d]", i), in_ready_w[i], 0);
                chk($sformatf("rst_out_valid[%0d]", i), out_valid_w[i], 0);
                chk($sformatf("rst_out_bin[%0d]", i), out_bin_w[i], 0);
                chk($sformatf("rst_out_err[%0d]", i), out_err_w[i], 0);
            end
            mdl_busy = 0;
            mdl_age  = 0;
        end else begin
            exp_vld = mdl_busy && (mdl_age >= NDIG + 1);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("in_ready[%0d]", i), in_ready_w[i], int'(!mdl_busy));
                chk($sformatf("out_valid[%0d]", i), out_valid_w[i], int'(exp_vld));
                if (exp_vld) begin
                    chk($sformatf("out_bin[%0d]", i), out_bin_w[i], mdl_bin[i]);
                    chk($sformatf("out_err[%0d]", i), out_err_w[i], mdl_err[i]);
                end
            end
            // predict the coming rising edge
            if (!mdl_busy) begin
                if (in_valid) begin
                    mdl_busy = 1;
                    mdl_age  = 0;
                    for (int i = 0; i < 2; i++) begin
                        ref_conv(in_bcd, max_of(i), b, e);
                        mdl_bin[i] = b;
                        mdl_err[i] = e;
                    end
                end
            end else if (exp_vld && out_ready) begin
                mdl_busy = 0;
            end else if (mdl_age < 1000) begin
                mdl_age++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!in_ready_w[0] && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk({name, "_ready_timeout"}, 0, 1);
    endtask

    // Send one word with out_ready high; pin latency and both results to literals.
    task automatic run_word(input logic [7:0] bcd, input int b0, input int e0,
                            input int b1, input int e1);
        int lat;
        in_valid  = 1'b1;
        in_bcd    = bcd;
        out_ready = 1'b1;
        wait_ready($sformatf("w%02h", bcd));
        tick();                          // accept edge
        in_valid = 1'b0;
        chk($sformatf("w%02h_in_ready_low", bcd), in_ready_w[0], 0);
        lat = 0;
        while (!out_valid_w[0] && lat < 20) begin
            tick();
            lat++;
        end
        chk($sformatf("w%02h_latency", bcd), lat, 3);
        chk($sformatf("w%02h_bin99", bcd), out_bin_w[0], b0);
        chk($sformatf("w%02h_err99", bcd), out_err_w[0], e0);
        chk($sformatf("w%02h_bin59", bcd), out_bin_w[1], b1);
        chk($sformatf("w%02h_err59", bcd), out_err_w[1], e1);
        tick();                          // handshake edge
        chk($sformatf("w%02h_in_ready_back", bcd), in_ready_w[0], 1);
    endtask

    function automatic logic [7:0] rnd_bcd();
        logic [7:0] v;
        for (int k = 0; k < 2; k++) begin
            if ($urandom_range(0, 7) == 0) v[4*k +: 4] = 4'($urandom_range(10, 15));
            else                           v[4*k +: 4] = 4'($urandom_range(0, 9));
        end
        return v;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int n;
        #2;
        chk("reset_in_ready", in_ready_w[0], 0);
        chk("reset_out_valid", out_valid_w[0], 0);
        chk("reset_out_bin", out_bin_w[0], 0);
        tick(); tick(); tick();
        rst = 1'b0;
        #1;
        chk("post_reset_in_ready", in_ready_w[0], 1);

        run_word(8'h42, 42, 0, 42, 0);
        run_word(8'h99, 99, 0, 0, 1);
        run_word(8'h00, 0, 0, 0, 0);
        run_word(8'h59, 59, 0, 59, 0);
        run_word(8'h60, 60, 0, 0, 1);
        run_word(8'h3A, 0, 1, 0, 1);
        run_word(8'hB2, 0, 1, 0, 1);

        // Result held under back-pressure; a competing word is not taken.
        in_valid  = 1'b1;
        in_bcd    = 8'h17;
        out_ready = 1'b0;
        wait_ready("hold");
        tick();
        in_bcd = 8'h88;
        n = 0;
        while (!out_valid_w[0] && n < 20) begin
            tick();
            n++;
        end
        for (int c = 0; c < 5; c++) begin
            chk("hold_out_valid", out_valid_w[0], 1);
            chk("hold_out_bin", out_bin_w[0], 17);
            chk("hold_in_ready", in_ready_w[0], 0);
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        chk("hold_released_out_valid", out_valid_w[0], 0);
        chk("hold_released_in_ready", in_ready_w[0], 1);

        // Reset mid-CONV.
        in_valid = 1'b1;
        in_bcd   = 8'h73;
        wait_ready("rst_conv");
        tick();
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_conv_out_valid", out_valid_w[0], 0);
        chk("rst_conv_out_bin", out_bin_w[0], 0);
        chk("rst_conv_in_ready", in_ready_w[0], 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_conv_release_in_ready", in_ready_w[0], 1);
        run_word(8'h25, 25, 0, 25, 0);

        // Reset mid-DONE with a result on the outputs.
        in_valid  = 1'b1;
        in_bcd    = 8'h64;
        out_ready = 1'b0;
        wait_ready("rst_done");
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid_w[0] && n < 20) begin
            tick();
            n++;
        end
        chk("rst_done_pre_bin", out_bin_w[0], 64);
        #1 rst = 1'b1;
        #1;
        chk("rst_done_out_valid", out_valid_w[0], 0);
        chk("rst_done_out_bin", out_bin_w[0], 0);
        chk("rst_done_out_err59", out_err_w[1], 0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_bcd    = rnd_bcd();
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
